// File: rtl/obi_mem_responder.sv
// ---------------------------------------------------------------------------
// obi_mem_responder
//
// OBI-style memory responder for a single initiator. Requests are accepted
// with a combinational grant, the backing word-addressed RAM is accessed at
// the grant edge, and the response {valid, err, data} travels down a
// LATENCY-deep pipeline so that every granted request is answered exactly
// LATENCY cycles later, strictly in grant order.
//
// Ports
//   clk_i     in   1        clock, rising edge
//   rst_i     in   1        asynchronous reset, active-high
//   stall_i   in   1        backpressure injection; forces gnt_o low
//   req_i     in   1        request valid
//   gnt_o     out  1        request accepted this cycle
//   addr_i    in   32       byte address
//   we_i      in   1        1 = write, 0 = read
//   be_i      in   MEM_W/8  byte enables (writes only)
//   wdata_i   in   MEM_W    write data
//   rvalid_o  out  1        response valid, one per granted request
//   rdata_o   out  MEM_W    read data (0 for writes, errors and idle cycles)
//   err_o     out  1        response error, valid with rvalid_o
// ---------------------------------------------------------------------------
module obi_mem_responder #(
   parameter int          MEM_W           = 32,
   parameter int          DEPTH_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          LATENCY         = 2,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               req_i,
   output logic               gnt_o,
   input  logic [31:0]        addr_i,
   input  logic               we_i,
   input  logic [MEM_W/8-1:0] be_i,
   input  logic [MEM_W-1:0]   wdata_i,
   output logic               rvalid_o,
   output logic [MEM_W-1:0]   rdata_o,
   output logic               err_o
);

   localparam int NB       = MEM_W / 8;
   localparam int OFF_BITS = $clog2(NB);
   localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [32:0]      offset_ext;
   logic [31:0]      word_off;
   logic             in_range;
   logic [IDX_W-1:0] idx;

   // The extra top bit is the borrow of addr_i - BASE_ADDR: set means the
   // address lies below the window.
   assign offset_ext = {1'b0, addr_i} - {1'b0, BASE_ADDR};
   assign word_off   = offset_ext[31:0] >> OFF_BITS;
   assign in_range   = ~offset_ext[32] && (word_off < 32'(DEPTH_WORDS));
   assign idx        = word_off[IDX_W-1:0];

   // ------------------------------------------------------------------
   // Grant and outstanding counter
   // ------------------------------------------------------------------
   logic             gnt;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [LATENCY-1:0] valid_reg;
   logic [LATENCY-1:0] err_reg;

   // A response leaving this cycle frees its slot, so a full counter still
   // grants when rvalid_o is high.
   assign gnt = req_i & ~stall_i & ~rst_i &
                ((cnt_reg < CNT_W'(MAX_OUTSTANDING)) | rvalid_o);

   always_comb begin
      cnt_next = cnt_reg;
      case ({gnt, rvalid_o})
         2'b10:   cnt_next = cnt_reg + CNT_W'(1);
         2'b01:   cnt_next = cnt_reg - CNT_W'(1);
         default: cnt_next = cnt_reg;
      endcase
   end

   // ------------------------------------------------------------------
   // RAM with byte-lane write enables and registered read port
   // ------------------------------------------------------------------
   logic [MEM_W-1:0] mem [DEPTH_WORDS];
   logic [MEM_W-1:0] ram_q_reg;
   logic             wr_en;
   logic [NB-1:0]    lane_we;

   assign wr_en = gnt & we_i & in_range;

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_we[gi] = wr_en & be_i[gi];
   end

   // Read and write share the grant edge; the non-blocking read returns the
   // pre-write word. No reset here so the array and its output register map
   // onto block RAM.
   always_ff @(posedge clk_i) begin
      if (gnt) begin
         ram_q_reg <= mem[idx];
      end
      for (int b = 0; b < NB; b++) begin
         if (lane_we[b]) begin
            mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Response pipeline: valid/err shift registers plus data stages
   // ------------------------------------------------------------------
   logic             rd_ok_reg;   // stage 0 holds an in-range read
   logic [MEM_W-1:0] stage0_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_reg   <= '0;
         valid_reg <= '0;
         err_reg   <= '0;
         rd_ok_reg <= 1'b0;
      end else begin
         cnt_reg      <= cnt_next;
         valid_reg[0] <= gnt;
         err_reg[0]   <= gnt & ~in_range;
         rd_ok_reg    <= gnt & ~we_i & in_range;
         for (int i = 1; i < LATENCY; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            err_reg[i]   <= err_reg[i-1];
         end
      end
   end

   // Writes, errors and empty slots carry zero data, so rdata_o is zero on
   // every cycle without a read response.
   assign stage0_data = rd_ok_reg ? ram_q_reg : '0;

   if (LATENCY == 1) begin : g_lat1
      assign rdata_o = stage0_data;
   end else begin : g_pipe
      logic [LATENCY-2:0][MEM_W-1:0] data_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            data_reg <= '0;
         end else begin
            data_reg[0] <= stage0_data;
            for (int i = 1; i < LATENCY - 1; i++) begin
               data_reg[i] <= data_reg[i-1];
            end
         end
      end

      assign rdata_o = data_reg[LATENCY-2];
   end

   assign gnt_o    = gnt;
   assign rvalid_o = valid_reg[LATENCY-1];
   assign err_o    = err_reg[LATENCY-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_obi_mem_responder
//
// Instance dut uses the default parameters and is checked every cycle
// against a queue-based model of the responder. Instance dut_b runs with
// MAX_OUTSTANDING=1 to exercise slot reuse. Directed sequences also pin
// grant/response cycles and data against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_obi_mem_responder;

   localparam int LAT  = 2;
   localparam int MAXO = 4;

   logic        clk_i   = 1'b0;
   logic        rst_i   = 1'b1;
   logic        stall_i = 1'b0;
   logic        req_i   = 1'b0;
   logic [31:0] addr_i  = 32'h0;
   logic        we_i    = 1'b0;
   logic [3:0]  be_i    = 4'h0;
   logic [31:0] wdata_i = 32'h0;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   logic        b_req   = 1'b0;
   logic [31:0] b_addr  = 32'h0000_0020;
   logic [31:0] b_wdata = 32'hCAFE_0000;
   logic        b_gnt;
   logic        b_rvalid;
   logic [31:0] b_rdata;
   logic        b_err;

   always #5 clk_i = ~clk_i;

   obi_mem_responder #(
      .MEM_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0),
      .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .req_i(req_i),
      .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
      .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
   );

   obi_mem_responder #(
      .MEM_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0),
      .LATENCY(2), .MAX_OUTSTANDING(1)
   ) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(1'b0), .req_i(b_req),
      .gnt_o(b_gnt), .addr_i(b_addr), .we_i(1'b1), .be_i(4'hF),
      .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
   );

   // ------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          due;
      bit          err;
      bit          known;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      int          cyc;
      bit          err;
      logic [31:0] data;
   } ev_t;

   rsp_t        m_q[$];
   logic [31:0] m_mem   [1024];
   bit          m_known [1024];
   int          a_gnt[$];
   ev_t         a_rsp[$];
   int          b_gnt_log[$];
   int          b_rsp_log[$];
   int          b_out = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic miss(input string name, input int exp_cyc);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event missing, expected at cycle %0d", name, exp_cyc);
   endtask

   task automatic chk_gnt(input string name, input int i, input int exp_cyc);
      if (i < a_gnt.size()) chk(name, 32'(a_gnt[i]), 32'(exp_cyc));
      else miss(name, exp_cyc);
   endtask

   task automatic chk_rsp(input string name, input int i, input int exp_cyc,
                          input bit exp_err, input logic [31:0] exp_data);
      if (i < a_rsp.size()) begin
         chk({name, "_cycle"}, 32'(a_rsp[i].cyc), 32'(exp_cyc));
         chk({name, "_err"},   32'(a_rsp[i].err), 32'(exp_err));
         chk({name, "_rdata"}, a_rsp[i].data, exp_data);
      end else begin
         miss(name, exp_cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Model and per-cycle compare (negedge: inputs stable, outputs settled)
   // ------------------------------------------------------------------
   always @(negedge clk_i) begin : model
      rsp_t r;
      bit   due;
      bit   exp_gnt;
      bit   ok;
      int   idx;

      if (rst_i) begin
         m_q.delete();
         b_out = 0;
      end
      due     = (m_q.size() > 0) && (m_q[0].due == cyc);
      exp_gnt = req_i && !stall_i && !rst_i && ((m_q.size() < MAXO) || due);
      chk("gnt", 32'(gnt_o), 32'(exp_gnt));

      if (due) begin
         r = m_q.pop_front();
         chk("rvalid", 32'(rvalid_o), 32'd1);
         chk("err", 32'(err_o), 32'(r.err));
         if (r.known) chk("rdata", rdata_o, r.data);
      end else begin
         chk("rvalid_idle", 32'(rvalid_o), 32'd0);
         chk("err_idle", 32'(err_o), 32'd0);
         chk("rdata_idle", rdata_o, 32'd0);
      end

      if (exp_gnt) begin
         ok      = (addr_i < 32'h0000_1000);
         idx     = int'(addr_i[11:2]);
         r.due   = cyc + LAT;
         r.err   = !ok;
         r.known = 1'b1;
         r.data  = 32'h0;
         if (ok && !we_i) begin
            r.known = m_known[idx];
            r.data  = m_mem[idx];
         end
         if (ok && we_i) begin
            for (int b = 0; b < 4; b++)
               if (be_i[b]) m_mem[idx][b*8 +: 8] = wdata_i[b*8 +: 8];
            m_known[idx] = m_known[idx] || (be_i == 4'hF);
         end
         m_q.push_back(r);
      end

      if (gnt_o)    a_gnt.push_back(cyc);
      if (rvalid_o) a_rsp.push_back('{cyc, err_o, rdata_o});

      if (b_gnt) begin
         b_gnt_log.push_back(cyc);
         b_out++;
      end
      if (b_rvalid) begin
         b_rsp_log.push_back(cyc);
         b_out--;
         chk("b_err", 32'(b_err), 32'd0);
      end
      chk("b_rdata", b_rdata, 32'd0);
      chk("b_outstanding_le_1", 32'(b_out <= 1), 32'd1);

      cyc++;
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Presents one request and holds it until granted; the first stall_n
   // cycles are presented with stall_i high.
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] be,
                        input logic [31:0] d, input int stall_n);
      int  n;
      bit  done;
      n       = 0;
      done    = 1'b0;
      req_i   = 1'b1;
      addr_i  = a;
      we_i    = w;
      be_i    = be;
      wdata_i = d;
      while (!done) begin
         stall_i = (n < stall_n);
         @(negedge clk_i);
         done = gnt_o;
         @(posedge clk_i);
         #1;
         n++;
         if (!done && n > 20) begin
            miss("issue_timeout", cyc);
            done = 1'b1;
         end
      end
      req_i   = 1'b0;
      stall_i = 1'b0;
   endtask

   task automatic clear_logs();
      a_gnt.delete();
      a_rsp.delete();
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int c;

      // Reset with a pending request: no grant while rst_i is high.
      req_i  = 1'b1;
      addr_i = 32'h10;
      step(3);
      chk("reset_gnt", 32'(gnt_o), 32'd0);
      chk("reset_rvalid", 32'(rvalid_o), 32'd0);
      chk("reset_err", 32'(err_o), 32'd0);
      chk("reset_rdata", rdata_o, 32'd0);
      rst_i = 1'b0;
      req_i = 1'b0;
      step(1);

      // Preload words 0..3.
      issue(32'h0, 1'b1, 4'hF, 32'h1111_0000, 0);
      issue(32'h4, 1'b1, 4'hF, 32'h2222_0004, 0);
      issue(32'h8, 1'b1, 4'hF, 32'h3333_0008, 0);
      issue(32'hC, 1'b1, 4'hF, 32'h4444_000C, 0);
      step(5);

      // Full write then read back.
      clear_logs();
      c = cyc;
      issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 0);
      issue(32'h10, 1'b0, 4'h0, 32'h0, 0);
      step(5);
      chk_gnt("t1_wr_gnt", 0, c);
      chk_gnt("t1_rd_gnt", 1, c + 1);
      chk_rsp("t1_wr_rsp", 0, c + 2, 1'b0, 32'h0);
      chk_rsp("t1_rd_rsp", 1, c + 3, 1'b0, 32'hDEAD_BEEF);

      // Partial byte-enable write.
      clear_logs();
      c = cyc;
      issue(32'h10, 1'b1, 4'b0101, 32'h1122_3344, 0);
      issue(32'h10, 1'b0, 4'h0, 32'h0, 0);
      step(5);
      chk_rsp("t2_rd_rsp", 1, c + 3, 1'b0, 32'hDE22_BE44);

      // Back-to-back reads.
      clear_logs();
      c = cyc;
      issue(32'h0, 1'b0, 4'h0, 32'h0, 0);
      issue(32'h4, 1'b0, 4'h0, 32'h0, 0);
      issue(32'h8, 1'b0, 4'h0, 32'h0, 0);
      issue(32'hC, 1'b0, 4'h0, 32'h0, 0);
      step(6);
      chk("t3_n_gnt", 32'(a_gnt.size()), 32'd4);
      chk_gnt("t3_gnt3", 3, c + 3);
      chk_rsp("t3_rsp0", 0, c + 2, 1'b0, 32'h1111_0000);
      chk_rsp("t3_rsp1", 1, c + 3, 1'b0, 32'h2222_0004);
      chk_rsp("t3_rsp2", 2, c + 4, 1'b0, 32'h3333_0008);
      chk_rsp("t3_rsp3", 3, c + 5, 1'b0, 32'h4444_000C);

      // Same reads with one stall cycle in cycle 1.
      clear_logs();
      c = cyc;
      issue(32'h0, 1'b0, 4'h0, 32'h0, 0);
      issue(32'h4, 1'b0, 4'h0, 32'h0, 1);
      issue(32'h8, 1'b0, 4'h0, 32'h0, 0);
      issue(32'hC, 1'b0, 4'h0, 32'h0, 0);
      step(6);
      chk_gnt("t3s_gnt1", 1, c + 2);
      chk_gnt("t3s_gnt3", 3, c + 4);
      chk_rsp("t3s_rsp1", 1, c + 4, 1'b0, 32'h2222_0004);
      chk_rsp("t3s_rsp3", 3, c + 6, 1'b0, 32'h4444_000C);

      // MAX_OUTSTANDING=1 instance with req held high.
      c     = cyc;
      b_req = 1'b1;
      step(6);
      b_req = 1'b0;
      step(4);
      chk("t4_n_gnt", 32'(b_gnt_log.size()), 32'd3);
      chk("t4_n_rsp", 32'(b_rsp_log.size()), 32'd3);
      if (b_gnt_log.size() == 3 && b_rsp_log.size() == 3) begin
         chk("t4_gnt0", 32'(b_gnt_log[0]), 32'(c));
         chk("t4_gnt1", 32'(b_gnt_log[1]), 32'(c + 2));
         chk("t4_gnt2", 32'(b_gnt_log[2]), 32'(c + 4));
         chk("t4_rsp2", 32'(b_rsp_log[2]), 32'(c + 6));
      end

      // Out-of-range accesses and the last valid word.
      clear_logs();
      c = cyc;
      issue(32'h0000_1000, 1'b1, 4'hF, 32'hBAD0_BAD0, 0);
      issue(32'h0000_0000, 1'b0, 4'h0, 32'h0, 0);
      issue(32'h0000_0FFC, 1'b1, 4'hF, 32'h5A5A_5A5A, 0);
      issue(32'h0000_0FFC, 1'b0, 4'h0, 32'h0, 0);
      issue(32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0, 0);
      step(6);
      chk_rsp("t5_oor_wr", 0, c + 2, 1'b1, 32'h0);
      chk_rsp("t5_rd0", 1, c + 3, 1'b0, 32'h1111_0000);
      chk_rsp("t5_rd_last", 3, c + 5, 1'b0, 32'h5A5A_5A5A);
      chk_rsp("t5_oor_rd", 4, c + 6, 1'b1, 32'h0);

      // Reset while a read is in flight.
      clear_logs();
      c = cyc;
      issue(32'h10, 1'b0, 4'h0, 32'h0, 0);
      rst_i = 1'b1;
      step(1);
      rst_i = 1'b0;
      issue(32'h0, 1'b0, 4'h0, 32'h0, 0);
      step(6);
      chk("t6_n_gnt", 32'(a_gnt.size()), 32'd2);
      chk_gnt("t6_gnt_after_rst", 1, c + 2);
      chk("t6_n_rsp", 32'(a_rsp.size()), 32'd1);
      chk_rsp("t6_rsp", 0, c + 4, 1'b0, 32'h1111_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
